// File: rtl/dds_param_loader.sv
// Byte-stream command parser feeding the DDS control stage: framed writes land in shadow
// registers and a commit frame moves every shadow to the live outputs in one cycle.
//
// state  | meaning
// S_IDLE | waiting for 0xA5 start byte, other bytes dropped
// S_ADDR | next byte is the register address
// S_DATA | collecting 4 data bytes, MSB first
// S_CSUM | next byte is the XOR checksum, frame executes on it
module dds_param_loader #(
   parameter int                 TIMEOUT_CYC = 100000,
   parameter logic [31:0]        RST_FREQ    = 32'd0,
   parameter logic signed [5:0]  RST_AMP     = 6'sd31
) (
   input  logic                Clock,
   input  logic                Reset,
   input  logic [7:0]          rx_data,
   input  logic                rx_valid,
   output logic [31:0]         frequency,
   output logic signed [5:0]   amplitude,
   output logic signed [8:0]   duty_ratio,
   output logic [11:0]         bias,
   output logic [1:0]          wave_style,
   output logic                param_update,
   output logic                frame_err
);

   localparam int              CNT_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYC);

   localparam logic [7:0] START_BYTE = 8'hA5;
   localparam logic [7:0] A_FREQ     = 8'h00;
   localparam logic [7:0] A_AMP      = 8'h01;
   localparam logic [7:0] A_DUTY     = 8'h02;
   localparam logic [7:0] A_BIAS     = 8'h03;
   localparam logic [7:0] A_STYLE    = 8'h04;
   localparam logic [7:0] A_COMMIT   = 8'h05;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ADDR,
      S_DATA,
      S_CSUM
   } state_t;

   state_t state, next_state;

   logic [CNT_W-1:0]   idle_cnt;
   logic [1:0]         byte_cnt;
   logic [7:0]         addr_q;
   logic [7:0]         csum_acc;
   logic [31:0]        data_q;

   logic [31:0]        sh_freq;
   logic signed [5:0]  sh_amp;
   logic signed [8:0]  sh_duty;
   logic [11:0]        sh_bias;
   logic [1:0]         sh_style;

   logic timeout;
   logic frame_done;
   logic csum_ok;

   // A byte in the terminal-count cycle wins over the timeout.
   assign timeout    = (state != S_IDLE) && !rx_valid && (idle_cnt == TO_VAL);
   assign frame_done = (state == S_CSUM) && rx_valid;
   assign csum_ok    = (rx_data == csum_acc);

   always_ff @(posedge Clock) begin
      if (Reset) state <= S_IDLE;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: if (rx_valid && rx_data == START_BYTE) next_state = S_ADDR;
         S_ADDR: if (rx_valid) next_state = S_DATA;
         S_DATA: if (rx_valid && byte_cnt == 2'd3) next_state = S_CSUM;
         S_CSUM: if (rx_valid) next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
      if (timeout) next_state = S_IDLE;
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         idle_cnt <= '0;
         byte_cnt <= '0;
         addr_q   <= '0;
         csum_acc <= '0;
         data_q   <= '0;
      end else begin
         if (state == S_IDLE || rx_valid || timeout) idle_cnt <= '0;
         else                                        idle_cnt <= idle_cnt + CNT_W'(1);

         if (rx_valid) begin
            case (state)
               S_IDLE: begin
                  byte_cnt <= '0;
                  csum_acc <= '0;
               end
               S_ADDR: begin
                  addr_q   <= rx_data;
                  csum_acc <= rx_data;
               end
               S_DATA: begin
                  data_q   <= {data_q[23:0], rx_data};
                  csum_acc <= csum_acc ^ rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
               end
               default: ;
            endcase
         end
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         sh_freq      <= RST_FREQ;
         sh_amp       <= RST_AMP;
         sh_duty      <= '0;
         sh_bias      <= '0;
         sh_style     <= '0;
         frequency    <= RST_FREQ;
         amplitude    <= RST_AMP;
         duty_ratio   <= '0;
         bias         <= '0;
         wave_style   <= '0;
         param_update <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         param_update <= 1'b0;
         frame_err    <= 1'b0;
         if (timeout) begin
            frame_err <= 1'b1;
         end else if (frame_done) begin
            if (!csum_ok) begin
               frame_err <= 1'b1;
            end else begin
               case (addr_q)
                  A_FREQ:  sh_freq  <= data_q;
                  A_AMP:   sh_amp   <= $signed(data_q[5:0]);
                  A_DUTY:  sh_duty  <= $signed(data_q[8:0]);
                  A_BIAS:  sh_bias  <= data_q[11:0];
                  A_STYLE: sh_style <= data_q[1:0];
                  A_COMMIT: begin
                     frequency    <= sh_freq;
                     amplitude    <= sh_amp;
                     duty_ratio   <= sh_duty;
                     bias         <= sh_bias;
                     wave_style   <= sh_style;
                     param_update <= 1'b1;
                  end
                  default: frame_err <= 1'b1;
               endcase
            end
         end
      end
   end

endmodule

// File: tb/tb_dds_param_loader.sv
// Bench for dds_param_loader: table of frames with expected live outputs, plus a
// scoreboard of expected param_update/frame_err pulses checked for kind and exact cycle.
module tb_dds_param_loader;

   localparam int TO = 20;

   logic               Clock = 1'b0;
   logic               Reset = 1'b1;
   logic [7:0]         rx_data = 8'h00;
   logic               rx_valid = 1'b0;
   logic [31:0]        frequency;
   logic signed [5:0]  amplitude;
   logic signed [8:0]  duty_ratio;
   logic [11:0]        bias;
   logic [1:0]         wave_style;
   logic               param_update;
   logic               frame_err;

   dds_param_loader #(
      .TIMEOUT_CYC (TO),
      .RST_FREQ    (32'd0),
      .RST_AMP     (6'sd31)
   ) dut (
      .Clock        (Clock),
      .Reset        (Reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .frequency    (frequency),
      .amplitude    (amplitude),
      .duty_ratio   (duty_ratio),
      .bias         (bias),
      .wave_style   (wave_style),
      .param_update (param_update),
      .frame_err    (frame_err)
   );

   always #5 Clock = ~Clock;

   int cyc = 0;
   always @(posedge Clock) cyc <= cyc + 1;

   int errors = 0;
   int checks = 0;
   bit mon_en = 1'b0;

   typedef struct {
      bit          is_err;
      int          due;
      logic [31:0] f;
      logic [5:0]  a;
      logic [8:0]  d;
      logic [11:0] b;
      logic [1:0]  s;
   } exp_t;

   typedef struct {
      string       name;
      logic [7:0]  addr;
      logic [31:0] data;
      bit          bad;
      bit          exp_err;
      bit          exp_upd;
      logic [31:0] f;
      logic [5:0]  a;
      logic [8:0]  d;
      logic [11:0] b;
      logic [1:0]  s;
   } vec_t;

   exp_t sb_q[$];
   exp_t e_mon;
   vec_t vecs[16];

   task automatic check_outs(input string name, input logic [31:0] f, input logic [5:0] a,
                             input logic [8:0] d, input logic [11:0] b, input logic [1:0] s);
      checks++;
      if ({frequency, amplitude, duty_ratio, bias, wave_style} !== {f, a, d, b, s}) begin
         errors++;
         $display("FAIL %s: got f=%h a=%h d=%h b=%h s=%h, want f=%h a=%h d=%h b=%h s=%h",
                  name, frequency, amplitude, duty_ratio, bias, wave_style, f, a, d, b, s);
      end
   endtask

   task automatic push_exp(input bit is_err, input int due, input logic [31:0] f,
                           input logic [5:0] a, input logic [8:0] d, input logic [11:0] b,
                           input logic [1:0] s);
      exp_t e;
      e.is_err = is_err; e.due = due;
      e.f = f; e.a = a; e.d = d; e.b = b; e.s = s;
      sb_q.push_back(e);
   endtask

   // Drive one byte; returns the cycle index whose negedge shows any resulting pulse.
   task automatic send_byte(input logic [7:0] b, output int sampled);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge Clock);
      #1;
      rx_valid = 1'b0;
      sampled  = cyc;
   endtask

   task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input bit bad,
                             output int due);
      logic [7:0] cs;
      int s;
      cs = a ^ d[31:24] ^ d[23:16] ^ d[15:8] ^ d[7:0];
      if (bad) cs = ~cs;
      send_byte(8'hA5, s);
      send_byte(a, s);
      for (int k = 3; k >= 0; k--) send_byte(d[k*8 +: 8], s);
      send_byte(cs, due);
   endtask

   task automatic expect_commit(input logic [31:0] f, input logic [5:0] a, input logic [8:0] d,
                                input logic [11:0] b, input logic [1:0] s);
      int due;
      send_frame(8'h05, 32'h0, 1'b0, due);
      push_exp(1'b0, due, f, a, d, b, s);
      repeat (2) @(posedge Clock);
      #1;
   endtask

   always @(negedge Clock) begin
      if (mon_en && (param_update === 1'b1 || frame_err === 1'b1)) begin
         checks++;
         if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse: got upd=%b err=%b at cyc %0d, want no pulse",
                     param_update, frame_err, cyc);
         end else begin
            e_mon = sb_q.pop_front();
            if (frame_err !== e_mon.is_err || param_update !== !e_mon.is_err || cyc != e_mon.due) begin
               errors++;
               $display("FAIL pulse_kind_time: got upd=%b err=%b cyc=%0d, want upd=%b err=%b cyc=%0d",
                        param_update, frame_err, cyc, !e_mon.is_err, e_mon.is_err, e_mon.due);
            end
            if (!e_mon.is_err)
               check_outs("commit_values", e_mon.f, e_mon.a, e_mon.d, e_mon.b, e_mon.s);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, want normal finish");
      $fatal(1);
   end

   initial begin
      int due;
      int s;
      int c0;

      vecs[0]  = '{"wr_freq",    8'h00, 32'h12345678, 0, 0, 0, 32'h00000000, 6'h1F, 9'h000, 12'h000, 2'd0};
      vecs[1]  = '{"commit1",    8'h05, 32'h00000000, 0, 0, 1, 32'h12345678, 6'h1F, 9'h000, 12'h000, 2'd0};
      vecs[2]  = '{"wr_style",   8'h04, 32'h00000002, 0, 0, 0, 32'h12345678, 6'h1F, 9'h000, 12'h000, 2'd0};
      vecs[3]  = '{"wr_amp",     8'h01, 32'h00000015, 0, 0, 0, 32'h12345678, 6'h1F, 9'h000, 12'h000, 2'd0};
      vecs[4]  = '{"commit2",    8'h05, 32'h00000000, 0, 0, 1, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[5]  = '{"bad_csum",   8'h03, 32'h00000100, 1, 1, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[6]  = '{"commit3",    8'h05, 32'h00000000, 0, 0, 1, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[7]  = '{"bad_addr",   8'h07, 32'hDEADBEEF, 0, 1, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[8]  = '{"wr_duty",    8'h02, 32'hFFFF01FF, 0, 0, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[9]  = '{"wr_bias",    8'h03, 32'hFFFFF123, 0, 0, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[10] = '{"wr_amp_neg", 8'h01, 32'hFFFFFFE0, 0, 0, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[11] = '{"wr_style3",  8'h04, 32'hFFFFFFFF, 0, 0, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[12] = '{"wr_freq2",   8'h00, 32'hCAFEF00D, 0, 0, 0, 32'h12345678, 6'h15, 9'h000, 12'h000, 2'd2};
      vecs[13] = '{"commit4",    8'h05, 32'h12345678, 0, 0, 1, 32'hCAFEF00D, 6'h20, 9'h1FF, 12'h123, 2'd3};
      vecs[14] = '{"a5_as_data", 8'h00, 32'hA5A5A5A5, 0, 0, 0, 32'hCAFEF00D, 6'h20, 9'h1FF, 12'h123, 2'd3};
      vecs[15] = '{"commit5",    8'h05, 32'h00000000, 0, 0, 1, 32'hA5A5A5A5, 6'h20, 9'h1FF, 12'h123, 2'd3};

      repeat (3) @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      check_outs("reset_values", 32'h0, 6'h1F, 9'h000, 12'h000, 2'd0);
      checks++;
      if (param_update !== 1'b0 || frame_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_pulses: got upd=%b err=%b, want 0 0", param_update, frame_err);
      end
      mon_en = 1'b1;
      @(posedge Clock);
      #1;

      // Noise in IDLE must be ignored silently.
      send_byte(8'h05, s);
      send_byte(8'h00, s);
      send_byte(8'hFF, s);
      send_byte(8'h5A, s);

      for (int i = 0; i < 16; i++) begin
         send_frame(vecs[i].addr, vecs[i].data, vecs[i].bad, due);
         if (vecs[i].exp_err || vecs[i].exp_upd)
            push_exp(vecs[i].exp_err, due, vecs[i].f, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].s);
         repeat (2) @(posedge Clock);
         @(negedge Clock);
         check_outs(vecs[i].name, vecs[i].f, vecs[i].a, vecs[i].d, vecs[i].b, vecs[i].s);
         @(posedge Clock);
         #1;
      end

      // Stall after the address byte: timeout fires TO+1 cycles after it.
      send_byte(8'hA5, s);
      send_byte(8'h00, c0);
      push_exp(1'b1, c0 + TO + 1, 32'h0, 6'h0, 9'h0, 12'h0, 2'd0);
      repeat (TO + 4) @(posedge Clock);
      #1;
      send_frame(8'h00, 32'h0BADF00D, 1'b0, due);
      expect_commit(32'h0BADF00D, 6'h20, 9'h1FF, 12'h123, 2'd3);
      check_outs("after_timeout", 32'h0BADF00D, 6'h20, 9'h1FF, 12'h123, 2'd3);

      // Byte lands in the very cycle the count reaches TO: accepted, no timeout.
      send_byte(8'hA5, s);
      send_byte(8'h00, s);
      send_byte(8'h11, s);
      repeat (TO) @(posedge Clock);
      #1;
      send_byte(8'h22, s);
      send_byte(8'h33, s);
      send_byte(8'h44, s);
      send_byte(8'h44, s);
      expect_commit(32'h11223344, 6'h20, 9'h1FF, 12'h123, 2'd3);
      check_outs("just_in_time", 32'h11223344, 6'h20, 9'h1FF, 12'h123, 2'd3);

      // Reset after three data bytes, then the frame tail and a start-less commit tail.
      send_byte(8'hA5, s);
      send_byte(8'h00, s);
      send_byte(8'hDE, s);
      send_byte(8'hAD, s);
      send_byte(8'hBE, s);
      Reset = 1'b1;
      @(posedge Clock);
      #1;
      Reset = 1'b0;
      @(negedge Clock);
      check_outs("mid_frame_reset", 32'h0, 6'h1F, 9'h000, 12'h000, 2'd0);
      send_byte(8'hEF, s);
      send_byte(8'h00 ^ 8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF, s);
      send_byte(8'h05, s);
      for (int k = 0; k < 4; k++) send_byte(8'h00, s);
      send_byte(8'h05, s);
      repeat (3) @(posedge Clock);
      @(negedge Clock);
      check_outs("tail_ignored", 32'h0, 6'h1F, 9'h000, 12'h000, 2'd0);
      @(posedge Clock);
      #1;
      expect_commit(32'h0, 6'h1F, 9'h000, 12'h000, 2'd0);

      repeat (5) @(posedge Clock);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL missing_pulses: got %0d outstanding, want 0", sb_q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
